// File: rtl/lcd_hd44780_pkg.sv
// Shared types and constants for the HD44780 character-LCD controller:
// FSM state encoding, instruction bytes and the power-up init ROM.
package lcd_hd44780_pkg;

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    PWR_WAIT  = 3'd1,
    INIT_LOAD = 3'd2,
    SETUP     = 3'd3,
    EN_HIGH   = 3'd4,
    HOLD      = 3'd5,
    EXEC_WAIT = 3'd6,
    IDLE      = 3'd7
  } lcd_state_e;

  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_HOME      = 8'h02;
  localparam logic [7:0] LCD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] LCD_ENTRY_INC = 8'h06;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_DISP_OFF  = 8'h08;

  localparam int INIT_LEN   = 7;
  localparam int INIT_IDX_W = $clog2(INIT_LEN);

  // Entry 0 is the first byte written after power-up.
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
    LCD_DISP_ON, LCD_ENTRY_INC, LCD_CLEAR, LCD_DISP_OFF,
    LCD_FUNC_8B2L, LCD_FUNC_8B2L, LCD_FUNC_8B2L
  };

  // Clear and return-home (0x03 decodes as home too) need the long execution wait.
  function automatic logic is_long_exec(input logic rs, input logic [7:0] b);
    return (rs == 1'b0) && ((b == LCD_CLEAR) || (b == LCD_HOME) || (b == 8'h03));
  endfunction

endpackage

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 write-only controller: runs the power-up init sequence, then turns
// single-byte valid/ready writes into timed RS/DATA/EN strobes.
import lcd_hd44780_pkg::*;

module lcd_hd44780_ctrl #(
  parameter int unsigned POWERUP_CYC   = 32'd1_000_000,
  parameter int unsigned SETUP_CYC     = 32'd4,
  parameter int unsigned EN_HIGH_CYC   = 32'd25,
  parameter int unsigned HOLD_CYC      = 32'd4,
  parameter int unsigned EXEC_CYC      = 32'd2_500,
  parameter int unsigned EXEC_LONG_CYC = 32'd100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_on,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_byte,
  output logic       init_done,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       lcd_on
);

  localparam int unsigned MAX_A   = (POWERUP_CYC > EXEC_LONG_CYC) ? POWERUP_CYC : EXEC_LONG_CYC;
  localparam int unsigned MAX_B   = (EXEC_CYC > EN_HIGH_CYC) ? EXEC_CYC : EN_HIGH_CYC;
  localparam int unsigned MAX_C   = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int CNT_W = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  lcd_state_e              state_r, state_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s, cnt_dec_s;
  logic [INIT_IDX_W-1:0]   init_idx_r, init_idx_s;
  logic                    lat_rs_r, lat_rs_s;
  logic [7:0]              lat_byte_r, lat_byte_s;
  logic                    lcd_en_r, lcd_on_r, lcd_rs_r, init_done_r, cmd_ready_r;
  logic [7:0]              lcd_data_r;
  logic                    lcd_rs_s, init_done_s;
  logic [7:0]              lcd_data_s;

  // Counter reload value for a state being entered: its duration minus one.
  function automatic logic [CNT_W-1:0] load_val(input lcd_state_e st, input logic long_exec);
    case (st)
      PWR_WAIT:  load_val = CNT_W'(POWERUP_CYC - 32'd1);
      SETUP:     load_val = CNT_W'(SETUP_CYC - 32'd1);
      EN_HIGH:   load_val = CNT_W'(EN_HIGH_CYC - 32'd1);
      HOLD:      load_val = CNT_W'(HOLD_CYC - 32'd1);
      EXEC_WAIT: load_val = long_exec ? CNT_W'(EXEC_LONG_CYC - 32'd1) : CNT_W'(EXEC_CYC - 32'd1);
      default:   load_val = CNT_ZERO;
    endcase
  endfunction

  // Next-state, write latch and timing-counter logic; power loss overrides everything.
  always_comb begin
    state_s    = state_r;
    init_idx_s = init_idx_r;
    lat_rs_s   = lat_rs_r;
    lat_byte_s = lat_byte_r;
    cnt_dec_s  = (cnt_r == CNT_ZERO) ? CNT_ZERO : (cnt_r - CNT_ONE);
    cnt_s      = cnt_dec_s;
    if (power_on == 1'b0) begin
      state_s    = OFF;
      init_idx_s = {INIT_IDX_W{1'b0}};
    end else begin
      case (state_r)
        OFF: begin
          state_s    = PWR_WAIT;
          init_idx_s = {INIT_IDX_W{1'b0}};
        end
        PWR_WAIT:  state_s = (cnt_r == CNT_ZERO) ? INIT_LOAD : PWR_WAIT;
        INIT_LOAD: begin
          lat_rs_s   = 1'b0;
          lat_byte_s = INIT_ROM[init_idx_r];
          state_s    = SETUP;
        end
        SETUP:     state_s = (cnt_r == CNT_ZERO) ? EN_HIGH : SETUP;
        EN_HIGH:   state_s = (cnt_r == CNT_ZERO) ? HOLD : EN_HIGH;
        HOLD:      state_s = (cnt_r == CNT_ZERO) ? EXEC_WAIT : HOLD;
        EXEC_WAIT: begin
          if (cnt_r != CNT_ZERO) begin
            state_s = EXEC_WAIT;
          end else if (init_done_r || (init_idx_r == INIT_IDX_W'(INIT_LEN - 1))) begin
            state_s = IDLE;
          end else begin
            state_s    = INIT_LOAD;
            init_idx_s = init_idx_r + {{(INIT_IDX_W-1){1'b0}}, 1'b1};
          end
        end
        IDLE: begin
          if (cmd_valid && cmd_ready_r) begin
            lat_rs_s   = cmd_rs;
            lat_byte_s = cmd_byte;
            state_s    = SETUP;
          end else begin
            state_s = IDLE;
          end
        end
        default: state_s = OFF;
      endcase
    end
    if (state_s != state_r) begin
      cnt_s = load_val(state_s, is_long_exec(lat_rs_s, lat_byte_s));
    end else begin
      cnt_s = cnt_dec_s;
    end
  end

  // Next values of the registered LCD bus; EXEC_WAIT keeps whatever was last driven.
  always_comb begin
    lcd_rs_s   = 1'b0;
    lcd_data_s = 8'h00;
    case (state_s)
      SETUP, EN_HIGH, HOLD: begin
        lcd_rs_s   = lat_rs_s;
        lcd_data_s = lat_byte_s;
      end
      EXEC_WAIT: begin
        lcd_rs_s   = lcd_rs_r;
        lcd_data_s = lcd_data_r;
      end
      default: begin
        lcd_rs_s   = 1'b0;
        lcd_data_s = 8'h00;
      end
    endcase
    if (state_s == OFF) begin
      init_done_s = 1'b0;
    end else begin
      init_done_s = init_done_r | (state_s == IDLE);
    end
  end

  // State, counter, latch and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= OFF;
      cnt_r       <= CNT_ZERO;
      init_idx_r  <= {INIT_IDX_W{1'b0}};
      lat_rs_r    <= 1'b0;
      lat_byte_r  <= 8'h00;
      lcd_en_r    <= 1'b0;
      lcd_on_r    <= 1'b0;
      lcd_rs_r    <= 1'b0;
      lcd_data_r  <= 8'h00;
      init_done_r <= 1'b0;
      cmd_ready_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      init_idx_r  <= init_idx_s;
      lat_rs_r    <= lat_rs_s;
      lat_byte_r  <= lat_byte_s;
      lcd_en_r    <= (state_s == EN_HIGH);
      lcd_on_r    <= (state_s != OFF);
      lcd_rs_r    <= lcd_rs_s;
      lcd_data_r  <= lcd_data_s;
      init_done_r <= init_done_s;
      cmd_ready_r <= (state_s == IDLE);
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign init_done = init_done_r;
  assign lcd_data  = lcd_data_r;
  assign lcd_rs    = lcd_rs_r;
  assign lcd_rw    = 1'b0;
  assign lcd_en    = lcd_en_r;
  assign lcd_on    = lcd_on_r;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Scoreboard bench for lcd_hd44780_ctrl: expected EN pulses are queued by the
// stimulus and checked by an independent bus monitor; timing checked inline.
module tb_lcd_hd44780_ctrl;

  localparam int P  = 100;
  localparam int S  = 2;
  localparam int E  = 5;
  localparam int H  = 2;
  localparam int X  = 20;
  localparam int XL = 50;
  localparam int INIT_CYC = 1 + P + 7 * (1 + S + E + H) + 6 * X + XL;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       power_on = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_rs = 1'b0;
  logic [7:0] cmd_byte = 8'h00;
  logic       cmd_ready, init_done, lcd_rs, lcd_rw, lcd_en, lcd_on;
  logic [7:0] lcd_data;

  typedef struct packed { logic rs; logic [7:0] b; } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  lcd_hd44780_ctrl #(
    .POWERUP_CYC(P), .SETUP_CYC(S), .EN_HIGH_CYC(E),
    .HOLD_CYC(H), .EXEC_CYC(X), .EXEC_LONG_CYC(XL)
  ) dut (
    .clk(clk), .rst(rst), .power_on(power_on),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rs(cmd_rs), .cmd_byte(cmd_byte),
    .init_done(init_done), .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_en(lcd_en), .lcd_on(lcd_on)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor: pairs every EN pulse with the oldest expected write.
  logic       prev_en = 1'b0;
  logic [8:0] prev_v = 9'h000;
  int         run = 0;
  int         width = 0;
  logic [8:0] cap = 9'h000;
  int         glitch = 0;
  int         hold_left = 0;
  int         hold_bad = 0;
  always @(negedge clk) begin
    logic [8:0] cur;
    exp_t ex;
    cur = {lcd_rs, lcd_data};
    if (lcd_en && !prev_en) begin
      cap = cur; width = 1; glitch = 0;
      check("setup_time", ((prev_v == cur) && (run >= S)) ? 1 : 0, 1);
    end else if (lcd_en && prev_en) begin
      width++;
      if (cur != cap) glitch++;
    end else if (!lcd_en && prev_en) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {23'd0, cap}, 0);
      end else begin
        ex = sb.pop_front();
        check("pulse_byte", {23'd0, cap}, {23'd0, ex.rs, ex.b});
        if (lcd_on) begin
          check("en_width", width, E);
          check("en_stable", glitch, 0);
          hold_left = H; hold_bad = 0;
        end
      end
    end
    if (hold_left > 0) begin
      if (cur != cap) hold_bad++;
      hold_left--;
      if (hold_left == 0) check("hold_time", hold_bad, 0);
    end
    run    = (cur == prev_v) ? run + 1 : 1;
    prev_v = cur;
    prev_en = lcd_en;
  end

  task automatic push_init();
    logic [7:0] rom [7];
    rom = '{8'h38, 8'h38, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
    foreach (rom[i]) sb.push_back({1'b0, rom[i]});
  endtask

  // Called at a negedge; returns at the negedge where init_done is first seen.
  task automatic run_init();
    int j;
    bit got;
    push_init();
    power_on = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    j = 1;
    @(negedge clk);
    check("lcd_on_rise", lcd_on, 1);
    got = 0;
    while (j < 2000) begin
      if (init_done) begin got = 1; break; end
      @(posedge clk); j++; @(negedge clk);
    end
    check("init_done_cyc", got ? j : -1, INIT_CYC);
    check("ready_after_init", cmd_ready, 1);
  endtask

  // Called at a negedge; returns cycles until cmd_ready is seen (or -1).
  task automatic wait_ready(output int j);
    j = 0;
    while (j < 500) begin
      if (cmd_ready) return;
      @(posedge clk); j++; @(negedge clk);
    end
    j = -1;
  endtask

  task automatic do_write(input logic rs, input logic [7:0] b, input int exp_ret);
    int j, en_err, dat_err, w;
    bit got;
    cmd_rs = rs; cmd_byte = b; cmd_valid = 1'b1;
    wait_ready(w);
    check("ready_wait", (w >= 0) ? 1 : 0, 1);
    sb.push_back({rs, b});
    @(posedge clk); #1 cmd_valid = 1'b0;
    j = 1; en_err = 0; dat_err = 0; got = 0;
    while (j <= exp_ret + 20) begin
      @(negedge clk);
      if (j == 1) check("ready_drop", cmd_ready, 0);
      if (lcd_en !== ((j >= S + 1) && (j <= S + E))) en_err++;
      if ((j <= S + E + H) && ({lcd_rs, lcd_data} !== {rs, b})) dat_err++;
      if (cmd_ready) begin got = 1; break; end
      j++;
    end
    check("en_window", en_err, 0);
    check("data_window", dat_err, 0);
    check("ready_return", got ? j : -1, exp_ret);
    check("idle_bus_zero", {lcd_rs, lcd_data}, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // Reset and unpowered behaviour
    repeat (3) @(negedge clk);
    check("rst_outputs", {lcd_on, lcd_en, lcd_rs, lcd_rw, init_done, cmd_ready, lcd_data}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("off_unpowered", {lcd_on, cmd_ready, lcd_en}, 0);

    // Init with a write request held throughout: accepted once, at first IDLE
    cmd_rs = 1'b1; cmd_byte = 8'h5A; cmd_valid = 1'b1;
    run_init();
    sb.push_back({1'b1, 8'h5A});
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("held_accept_drop", cmd_ready, 0);

    // Data and instruction writes
    do_write(1'b1, 8'h41, 1 + S + E + H + X);
    do_write(1'b0, 8'h01, 1 + S + E + H + XL);
    do_write(1'b0, 8'h80, 1 + S + E + H + X);
    do_write(1'b0, 8'h02, 1 + S + E + H + XL);

    // Valid held across EXEC_WAIT: second byte accepted only when IDLE returns
    cmd_rs = 1'b1; cmd_byte = 8'h43; cmd_valid = 1'b1;
    wait_ready(w);
    sb.push_back({1'b1, 8'h43});
    @(posedge clk); #1 cmd_byte = 8'h44;
    sb.push_back({1'b1, 8'h44});
    @(negedge clk);
    wait_ready(w);
    check("held_exec_accept", w + 1, 1 + S + E + H + X);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("held_exec_drop", cmd_ready, 0);
    wait_ready(w);

    // Power loss during EN_HIGH
    cmd_rs = 1'b1; cmd_byte = 8'h41; cmd_valid = 1'b1;
    wait_ready(w);
    sb.push_back({1'b1, 8'h41});
    @(posedge clk); #1 cmd_valid = 1'b0;
    w = 0;
    do begin @(negedge clk); w++; end while (!lcd_en && w < 50);
    check("en_seen_before_drop", lcd_en, 1);
    power_on = 1'b0;
    @(posedge clk); @(negedge clk);
    check("pwr_drop_outputs", {lcd_en, lcd_on, init_done, cmd_ready, lcd_rs, lcd_data}, 0);
    repeat (4) @(negedge clk);
    check("pwr_off_stays", {lcd_on, lcd_en}, 0);
    run_init();

    // Asynchronous reset mid-EXEC_WAIT
    cmd_rs = 1'b1; cmd_byte = 8'h42; cmd_valid = 1'b1;
    wait_ready(w);
    sb.push_back({1'b1, 8'h42});
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (15) @(negedge clk);
    #1 rst = 1'b1;
    #1 check("async_rst", {lcd_on, lcd_en, lcd_rs, init_done, cmd_ready, lcd_data}, 0);
    @(negedge clk);
    run_init();

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
